// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow-pipeline entry type for the GPR hazard/forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RDY_EX   = 2'd0,
        RDY_MEM1 = 2'd1,
        RDY_MEM2 = 2'd2
    } rdy_e;

    typedef enum logic [1:0] {
        FWD_ID_GPR  = 2'b00,
        FWD_ID_WB   = 2'b01,
        FWD_ID_MEM1 = 2'b10,
        FWD_ID_MEM2 = 2'b11
    } fwd_id_e;

    typedef enum logic [1:0] {
        FWD_EX_GPR  = 2'b00,
        FWD_EX_MEM1 = 2'b01,
        FWD_EX_MEM2 = 2'b11
    } fwd_ex_e;

    // valid is only set for GPR writers, so it doubles as the write-enable.
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        rdy_e       rdy;
    } entry_t;

    function automatic logic entry_match(entry_t e, logic [4:0] r);
        return e.valid && (e.dst == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_operand_chk.sv
// Per-operand forwarding select and stall generation against the four shadow entries.
module hazard_operand_chk
    import hazard_pkg::*;
(
    input  logic [4:0] operand,
    input  logic       use_id,
    input  logic       use_ex,
    input  entry_t     ex_e,
    input  entry_t     mem1_e,
    input  entry_t     mem2_e,
    input  entry_t     wb_e,
    output logic [1:0] fwd_id,
    output logic [1:0] fwd_ex,
    output logic       stall
);

    logic m_ex, m_mem1, m_mem2, m_wb;
    logic stall_id_term, stall_ex_term;
    logic unused_rdy;

    assign m_ex   = entry_match(ex_e,   operand);
    assign m_mem1 = entry_match(mem1_e, operand);
    assign m_mem2 = entry_match(mem2_e, operand);
    assign m_wb   = entry_match(wb_e,   operand);
    assign unused_rdy = ^{mem2_e.rdy, wb_e.rdy};

    // Youngest match wins: the if-chain is ordered EX, MEM1, MEM2, WB.
    always_comb begin
        fwd_id        = FWD_ID_GPR;
        stall_id_term = 1'b0;
        if (use_id) begin
            if (m_ex) begin
                stall_id_term = 1'b1;
            end else if (m_mem1) begin
                if (mem1_e.rdy == RDY_MEM2) stall_id_term = 1'b1;
                else                        fwd_id = FWD_ID_MEM1;
            end else if (m_mem2) begin
                fwd_id = FWD_ID_MEM2;
            end else if (m_wb) begin
                fwd_id = FWD_ID_WB;
            end
        end
    end

    // Selects are for the consumer's EX cycle, when each producer has moved one stage on.
    always_comb begin
        fwd_ex        = FWD_EX_GPR;
        stall_ex_term = 1'b0;
        if (use_ex) begin
            if (m_ex) begin
                if (ex_e.rdy != RDY_EX) stall_ex_term = 1'b1;
                else                    fwd_ex = FWD_EX_MEM1;
            end else if (m_mem1) begin
                fwd_ex = FWD_EX_MEM2;
            end
        end
    end

    assign stall = stall_id_term | stall_ex_term;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Shadow pipeline of in-flight GPR writers producing ID/EX forwarding selects, stall_id and divide busy.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       flush,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_use_id,
    input  logic       id_rt_use_id,
    input  logic       id_rs_use_ex,
    input  logic       id_rt_use_ex,
    input  logic       id_we,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_rdy,
    input  logic       id_div,
    input  logic       id_hilo_use,
    output logic       stall_id,
    output logic [1:0] fwd_id_rs,
    output logic [1:0] fwd_id_rt,
    output logic [1:0] fwd_ex_rs,
    output logic [1:0] fwd_ex_rt,
    output logic       div_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    entry_t ex_q, mem1_q, mem2_q, wb_q, id_entry;
    logic [1:0] fwd_ex_rs_nx, fwd_ex_rt_nx;
    logic stall_rs, stall_rt;
    logic [CNT_W-1:0] div_cnt;

    hazard_operand_chk u_chk_rs (
        .operand (id_rs),
        .use_id  (id_rs_use_id),
        .use_ex  (id_rs_use_ex),
        .ex_e    (ex_q),
        .mem1_e  (mem1_q),
        .mem2_e  (mem2_q),
        .wb_e    (wb_q),
        .fwd_id  (fwd_id_rs),
        .fwd_ex  (fwd_ex_rs_nx),
        .stall   (stall_rs)
    );

    hazard_operand_chk u_chk_rt (
        .operand (id_rt),
        .use_id  (id_rt_use_id),
        .use_ex  (id_rt_use_ex),
        .ex_e    (ex_q),
        .mem1_e  (mem1_q),
        .mem2_e  (mem2_q),
        .wb_e    (wb_q),
        .fwd_id  (fwd_id_rt),
        .fwd_ex  (fwd_ex_rt_nx),
        .stall   (stall_rt)
    );

    assign div_busy = (div_cnt != '0);
    assign stall_id = stall_rs | stall_rt | (id_hilo_use & div_busy);

    always_comb begin
        id_entry       = '0;
        id_entry.valid = id_we;
        id_entry.dst   = id_dst;
        id_entry.rdy   = rdy_e'(id_rdy);
    end

    // flush kills the MEM1 occupant, so MEM2 receives a bubble while WB still takes MEM2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem1_q    <= '0;
            mem2_q    <= '0;
            wb_q      <= '0;
            fwd_ex_rs <= '0;
            fwd_ex_rt <= '0;
        end else if (flush) begin
            wb_q      <= mem2_q;
            mem2_q    <= '0;
            mem1_q    <= '0;
            ex_q      <= '0;
            fwd_ex_rs <= '0;
            fwd_ex_rt <= '0;
        end else if (!hold) begin
            wb_q   <= mem2_q;
            mem2_q <= mem1_q;
            mem1_q <= ex_q;
            if (!stall_id) begin
                ex_q      <= id_entry;
                fwd_ex_rs <= fwd_ex_rs_nx;
                fwd_ex_rt <= fwd_ex_rt_nx;
            end else begin
                ex_q      <= '0;
                fwd_ex_rs <= '0;
                fwd_ex_rt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (flush) begin
            div_cnt <= '0;
        end else if (!hold && !stall_id && id_div) begin
            div_cnt <= DIV_LOAD;
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit with DIV_CYCLES=4.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0, flush = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_rs_use_id = 1'b0, id_rt_use_id = 1'b0;
    logic       id_rs_use_ex = 1'b0, id_rt_use_ex = 1'b0;
    logic       id_we = 1'b0, id_div = 1'b0, id_hilo_use = 1'b0;
    logic [1:0] id_rdy = '0;
    logic       stall_id, div_busy;
    logic [1:0] fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_fwd_unit #(.DIV_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .flush        (flush),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_use_id (id_rs_use_id),
        .id_rt_use_id (id_rt_use_id),
        .id_rs_use_ex (id_rs_use_ex),
        .id_rt_use_ex (id_rt_use_ex),
        .id_we        (id_we),
        .id_dst       (id_dst),
        .id_rdy       (id_rdy),
        .id_div       (id_div),
        .id_hilo_use  (id_hilo_use),
        .stall_id     (stall_id),
        .fwd_id_rs    (fwd_id_rs),
        .fwd_id_rt    (fwd_id_rt),
        .fwd_ex_rs    (fwd_ex_rs),
        .fwd_ex_rt    (fwd_ex_rt),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the ID instruction; rdy: 0=EX 1=MEM1 2=MEM2.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic rs_id, input logic rt_id,
                         input logic rs_ex, input logic rt_ex,
                         input logic we, input logic [4:0] dst, input logic [1:0] rdy,
                         input logic dv, input logic hl);
        id_rs = rs; id_rt = rt;
        id_rs_use_id = rs_id; id_rt_use_id = rt_id;
        id_rs_use_ex = rs_ex; id_rt_use_ex = rt_ex;
        id_we = we; id_dst = dst; id_rdy = rdy;
        id_div = dv; id_hilo_use = hl;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0);
    endtask

    task automatic do_reset();
        hold = 1'b0; flush = 1'b0;
        nop();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(5'd5, 5'd6, 1, 1, 1, 1, 1, 5'd5, 2'd2, 0, 1);
        step();
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall_id); end
        n_cmp++; if (fwd_id_rs !== 2'b00) begin n_bad++; $display("FAIL reset_fwd_id_rs got=%b exp=00", fwd_id_rs); end
        n_cmp++; if (fwd_id_rt !== 2'b00) begin n_bad++; $display("FAIL reset_fwd_id_rt got=%b exp=00", fwd_id_rt); end
        n_cmp++; if ({fwd_ex_rs, fwd_ex_rt} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd_ex got=%b exp=0000", {fwd_ex_rs, fwd_ex_rt}); end
        n_cmp++; if (div_busy !== 1'b0) begin n_bad++; $display("FAIL reset_div_busy got=%b exp=0", div_busy); end
        rst_n = 1'b1;
        nop();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd8, 2'd2, 1, 0); // LW r8 that also looks like DIV
        step();
        drive(5'd8, 5'd8, 1, 0, 0, 1, 0, 5'd0, 2'd0, 0, 1);
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL mid_pre_stall got=%b exp=1", stall_id); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL mid_async_stall got=%b exp=0", stall_id); end
        n_cmp++; if (div_busy !== 1'b0) begin n_bad++; $display("FAIL mid_async_div_busy got=%b exp=0", div_busy); end
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (fwd_id_rs !== 2'b00) begin n_bad++; $display("FAIL mid_after_fwd_id_rs got=%b exp=00", fwd_id_rs); end
    endtask

    task automatic test_alu_use();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd5, 2'd0, 0, 0); // ADDU r5
        step();
        drive(5'd5, 5'd1, 0, 0, 1, 1, 1, 5'd6, 2'd0, 0, 0);
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL alu_stall got=%b exp=0", stall_id); end
        step();
        nop();
        n_cmp++; if (fwd_ex_rs !== 2'b01) begin n_bad++; $display("FAIL alu_fwd_ex_rs got=%b exp=01", fwd_ex_rs); end
        n_cmp++; if (fwd_ex_rt !== 2'b00) begin n_bad++; $display("FAIL alu_fwd_ex_rt got=%b exp=00", fwd_ex_rt); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd8, 2'd2, 0, 0); // LW r8
        step();
        drive(5'd1, 5'd8, 0, 0, 0, 1, 1, 5'd9, 2'd0, 0, 0);
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL lu_stall1 got=%b exp=1", stall_id); end
        step();
        n_cmp++; if (fwd_ex_rt !== 2'b00) begin n_bad++; $display("FAIL lu_bubble_fwd_ex_rt got=%b exp=00", fwd_ex_rt); end
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL lu_stall2 got=%b exp=0", stall_id); end
        step();
        nop();
        n_cmp++; if (fwd_ex_rt !== 2'b11) begin n_bad++; $display("FAIL lu_fwd_ex_rt got=%b exp=11", fwd_ex_rt); end
    endtask

    task automatic test_branch_load();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd3, 2'd2, 0, 0); // LW r3
        step();
        drive(5'd3, 5'd0, 1, 1, 0, 0, 0, 5'd0, 2'd0, 0, 0); // BEQ r3, r0
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL br_stall_ex got=%b exp=1", stall_id); end
        step();
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL br_stall_mem1 got=%b exp=1", stall_id); end
        step();
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL br_stall_mem2 got=%b exp=0", stall_id); end
        n_cmp++; if (fwd_id_rs !== 2'b11) begin n_bad++; $display("FAIL br_fwd_id_mem2 got=%b exp=11", fwd_id_rs); end
        n_cmp++; if (fwd_id_rt !== 2'b00) begin n_bad++; $display("FAIL br_fwd_id_rt_r0 got=%b exp=00", fwd_id_rt); end
        step();
        drive(5'd0, 5'd3, 1, 1, 0, 0, 0, 5'd0, 2'd0, 0, 0); // second branch on r3
        n_cmp++; if (fwd_id_rt !== 2'b01) begin n_bad++; $display("FAIL br_fwd_id_wb got=%b exp=01", fwd_id_rt); end
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL br_stall_wb got=%b exp=0", stall_id); end
    endtask

    task automatic test_r0_priority();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd0, 2'd2, 0, 0); // load to r0
        step();
        drive(5'd0, 5'd0, 1, 1, 1, 1, 0, 5'd0, 2'd0, 0, 0);
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL r0_stall got=%b exp=0", stall_id); end
        n_cmp++; if ({fwd_id_rs, fwd_id_rt} !== 4'b0000) begin n_bad++; $display("FAIL r0_fwd_id got=%b exp=0000", {fwd_id_rs, fwd_id_rt}); end
        step();
        nop();
        n_cmp++; if ({fwd_ex_rs, fwd_ex_rt} !== 4'b0000) begin n_bad++; $display("FAIL r0_fwd_ex got=%b exp=0000", {fwd_ex_rs, fwd_ex_rt}); end

        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd9, 2'd0, 0, 0); // older r9 writer
        step();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd9, 2'd1, 0, 0); // younger r9 writer (MUL)
        step();
        nop();
        step();
        drive(5'd9, 5'd9, 1, 0, 0, 1, 0, 5'd0, 2'd0, 0, 0);
        n_cmp++; if (fwd_id_rs !== 2'b10) begin n_bad++; $display("FAIL prio_fwd_id got=%b exp=10", fwd_id_rs); end
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL prio_stall got=%b exp=0", stall_id); end
        step();
        nop();
        n_cmp++; if (fwd_ex_rt !== 2'b11) begin n_bad++; $display("FAIL prio_fwd_ex got=%b exp=11", fwd_ex_rt); end
    endtask

    task automatic test_divide();
        int stalls = 0;
        bit done = 0;
        do_reset();
        drive(5'd1, 5'd2, 0, 0, 1, 1, 0, 5'd0, 2'd0, 1, 1); // DIV
        n_cmp++; if (div_busy !== 1'b0) begin n_bad++; $display("FAIL div_busy_pre got=%b exp=0", div_busy); end
        step();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd2, 2'd0, 0, 1); // MFLO r2
        n_cmp++; if (div_busy !== 1'b1) begin n_bad++; $display("FAIL div_busy_rise got=%b exp=1", div_busy); end
        for (int i = 0; i < 10 && !done; i++) begin
            if (stall_id) begin stalls++; step(); end
            else done = 1;
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL div_timeout got=stall exp=release"); end
        n_cmp++; if (stalls !== 4) begin n_bad++; $display("FAIL div_stall_cycles got=%0d exp=4", stalls); end
        n_cmp++; if (div_busy !== 1'b0) begin n_bad++; $display("FAIL div_busy_fall got=%b exp=0", div_busy); end
        step();
        drive(5'd2, 5'd0, 0, 0, 1, 0, 0, 5'd0, 2'd0, 0, 0);
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL div_mflo_use_stall got=%b exp=0", stall_id); end
        step();
        nop();
        n_cmp++; if (fwd_ex_rs !== 2'b01) begin n_bad++; $display("FAIL div_mflo_advanced got=%b exp=01", fwd_ex_rs); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 2'd0, 1, 0); // DIV
        step();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd7, 2'd2, 0, 0); // LW r7
        step();
        nop();
        step();
        drive(5'd7, 5'd7, 1, 0, 0, 1, 0, 5'd0, 2'd0, 0, 0);
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL fl_pre_stall got=%b exp=1", stall_id); end
        n_cmp++; if (div_busy !== 1'b1) begin n_bad++; $display("FAIL fl_pre_busy got=%b exp=1", div_busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL fl_post_stall got=%b exp=0", stall_id); end
        n_cmp++; if (div_busy !== 1'b0) begin n_bad++; $display("FAIL fl_post_busy got=%b exp=0", div_busy); end
        n_cmp++; if ({fwd_ex_rs, fwd_ex_rt} !== 4'b0000) begin n_bad++; $display("FAIL fl_fwd_ex got=%b exp=0000", {fwd_ex_rs, fwd_ex_rt}); end
    endtask

    task automatic test_hold();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd4, 2'd0, 0, 0); // ADDU r4
        step();
        drive(5'd4, 5'd0, 0, 0, 1, 0, 1, 5'd6, 2'd1, 0, 0); // MUL r6 <- r4
        step();
        drive(5'd6, 5'd4, 0, 1, 1, 0, 0, 5'd0, 2'd0, 0, 0);
        n_cmp++; if (fwd_ex_rs !== 2'b01) begin n_bad++; $display("FAIL hold_pre_fwd_ex got=%b exp=01", fwd_ex_rs); end
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (fwd_ex_rs !== 2'b01) begin n_bad++; $display("FAIL hold_fwd_ex_c%0d got=%b exp=01", c, fwd_ex_rs); end
            n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL hold_stall_c%0d got=%b exp=1", c, stall_id); end
            n_cmp++; if (fwd_id_rt !== 2'b10) begin n_bad++; $display("FAIL hold_fwd_id_c%0d got=%b exp=10", c, fwd_id_rt); end
        end
        hold = 1'b0;
        step();
        n_cmp++; if (fwd_ex_rs !== 2'b00) begin n_bad++; $display("FAIL hold_bubble_fwd_ex got=%b exp=00", fwd_ex_rs); end
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL hold_release_stall got=%b exp=0", stall_id); end
        n_cmp++; if (fwd_id_rt !== 2'b11) begin n_bad++; $display("FAIL hold_release_fwd_id got=%b exp=11", fwd_id_rt); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_alu_use();
        test_load_use();
        test_branch_load();
        test_r0_priority();
        test_divide();
        test_flush();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Producer-side companion to the GPR forwarding muxes in the MIPS pipeline (ID, EX, MEM1, MEM2, WB). It keeps its own shadow pipeline of in-flight register writers and generates the select codes the forwarding muxes consume:

- ID-stage branch-compare operand selects (combinational).
- EX-stage ALU operand selects (registered into EX).
- `stall_id` for load-use, MUL/CP0-use and HI/LO-while-divide hazards, using a multi-cycle divide busy counter.

## Interface
- `DIV_CYCLES`, default 32: cycles the divider stays busy after a DIV/DIVU enters EX.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  global freeze (cache miss); shadow pipeline and `fwd_ex_*` hold.
- `flush`  in  1  exception/eret; kills ID, EX, MEM1 entries.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the ID instruction.
- `id_rs_use_id`, `id_rt_use_id`  in  1 each  operand consumed in ID (branch compare).
- `id_rs_use_ex`, `id_rt_use_ex`  in  1 each  operand consumed in EX.
- `id_we`  in  1  ID instruction writes a GPR.
- `id_dst`  in  5  its destination (post-MUX1 address).
- `id_rdy`  in  2  stage where its result becomes valid: 0=EX (ALU), 1=MEM1 (MUL/CP0/PC+8), 2=MEM2 (load/SC).
- `id_div`  in  1  ID instruction is DIV/DIVU.
- `id_hilo_use`  in  1  ID instruction reads HI/LO or is MULT/DIV.
- `stall_id`  out  1  hold PC/IF/ID; insert bubble into EX.
- `fwd_id_rs`, `fwd_id_rt`  out  2 each  ID mux selects: 00=GPR, 01=WD(WB), 10=MEM1, 11=MEM2.
- `fwd_ex_rs`, `fwd_ex_rt`  out  2 each  EX mux selects: 00=GPR, 01=MEM1 data, 11=MEM2 data.
- `div_busy`  out  1  divide counter nonzero.

## Operation
- **Shadow entries.** Four entries: EX, MEM1, MEM2, WB. Each holds {valid, dst, rdy}.
- **Match.** An entry matches an operand when valid && we && dst == operand && dst != 0.
- **Priority.** The youngest matching entry decides; older matches are ignored.
- **ID selects (per operand with `use_id`):**
  - EX match: stall.
  - MEM1 match with rdy=2: stall.
  - MEM1 match with rdy≤1: 10.
  - MEM2 match: 11.
  - WB match: 01.
  - No match: 00.
- **EX selects (per operand with `use_ex`), computed in ID:**
  - EX match with rdy≠0: stall.
  - EX match with rdy=0: 01.
  - MEM1 match: 11.
  - Otherwise: 00 (regfile write-through covers WB).
  - The value is registered into `fwd_ex_*` when ID advances.
- **HI/LO hazard:** `id_hilo_use` && `div_busy` → stall.
- `stall_id` is the OR of all stall terms above.
- **Advance** (`!hold`):
  - WB←MEM2, MEM2←MEM1, MEM1←EX.
  - EX←ID fields if `!stall_id` && `!flush`; otherwise EX becomes a bubble (valid=0) and `fwd_ex_*`←00.
- **flush** (takes priority over normal advance, ignores `hold`): EX and MEM1 are cleared and `fwd_ex_*`←00. MEM2 and WB still shift.
- **Divide counter:**
  - Loads `DIV_CYCLES` when a DIV enters EX (advance with `id_div`, no stall, no flush).
  - Otherwise decrements to 0 every cycle, independent of `hold`.
  - `flush` clears it to 0.

## Timing
- Reset values: all entries invalid, `fwd_ex_*`=00, counter=0, `div_busy`=0.
- Outputs while in reset: `stall_id`=0 and `fwd_id_*`=00, because all entries are invalid.
- `stall_id` and `fwd_id_*` are combinational from the ID inputs and the entry registers; there is no path from the ID inputs to the registers without a clock edge.
- `fwd_ex_*` change only at the edge where ID advances into EX; they are stable for the whole EX cycle.
- `div_busy` rises the cycle after the DIV enters EX and stays high for exactly `DIV_CYCLES` cycles.
- Counter width is clog2(`DIV_CYCLES`+1).
- **hold && stall_id:** `hold` wins; nothing moves and no bubble is inserted.
- **Reset mid-operation:** asynchronous clear of all state; the first cycle after reset behaves as an empty pipeline.

## Structure
- **Package `hazard_pkg`:**
  - rdy codes RDY_EX/RDY_MEM1/RDY_MEM2.
  - ID select codes FWD_ID_GPR/WB/MEM1/MEM2.
  - EX select codes FWD_EX_GPR/MEM1/MEM2.
  - Entry struct {valid, dst, rdy}.
- **Sub-module `hazard_operand_chk`:** combinational, one instance per source operand (rs, rt). Inputs: operand, use_id, use_ex, four entries. Outputs: ID select, EX select, stall term.

## Test plan
- **ALU-use.** ADDU r5 in EX, next instruction uses r5 in EX. Expect: no stall; `fwd_ex_rs`=01 during the consumer's EX.
- **Load-use.** LW r8 in EX, ID reads r8 for EX. Expect: `stall_id`=1 for exactly 1 cycle, then `fwd_ex_rt`=11.
- **Branch on load.** LW r3 followed by BEQ r3. Expect: stall for 2 cycles; `fwd_id_rs`=11 when LW is in MEM2, then 01 when it reaches WB.
- **r0 and priority.**
  - Writer to r0 followed by a reader of r0: expect selects 00, no stall.
  - Two writers to r9 (MEM1 and MEM2): expect the younger (MEM1) to win.
- **Divide.** DIV with `DIV_CYCLES`=4 enters EX, then MFLO in ID. Expect: `stall_id` high for 4 cycles, `div_busy` falls, MFLO advances.
- **Flush and hold.**
  - `flush` while LW is in MEM1 and ID reads its dst: expect no stall next cycle, counter cleared.
  - `hold` for 3 cycles: expect `fwd_ex_*` and all entries unchanged.
